// File: rtl/flag_show_sequencer.sv
// Slideshow controller for the pride-flag renderers: debounced next/prev/pause
// buttons, frame-counted auto-advance and a left-to-right wipe between flags.
module flag_show_sequencer #(
  parameter int NUM_FLAGS    = 8,
  parameter int SEL_W        = 3,
  parameter int DWELL_FRAMES = 600,
  parameter int WIPE_STEP    = 16,
  parameter int H_ACTIVE     = 640,
  parameter int DEB_CYCLES   = 250000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic [9:0]             pix_x,
  input  logic [6*NUM_FLAGS-1:0] flag_colors,
  input  logic                   btn_next,
  input  logic                   btn_prev,
  input  logic                   btn_pause,
  output logic [5:0]             color,
  output logic [SEL_W-1:0]       cur_sel,
  output logic [SEL_W-1:0]       nxt_sel,
  output logic                   paused,
  output logic                   wiping
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic {
    SHOW = 1'b0,
    WIPE = 1'b1
  } state_t;

  // Bit order for all button vectors: {pause, prev, next}
  logic [2:0]       raw_s;
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       deb_r;
  logic [2:0]       press_r;
  logic [DEB_W-1:0] deb_cnt_r [3];

  state_t           state_r;
  logic [SEL_W-1:0] cur_sel_r;
  logic [SEL_W-1:0] nxt_sel_r;
  logic             paused_r;
  logic [15:0]      dwell_cnt_r;
  logic [10:0]      wipe_x_r;
  logic [5:0]       color_r;

  assign raw_s = {btn_pause, btn_prev, btn_next};

  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(NUM_FLAGS - 1)) ? SEL_W'(0) : s + SEL_W'(1);
  endfunction

  function automatic logic [SEL_W-1:0] sel_dec(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(0)) ? SEL_W'(NUM_FLAGS - 1) : s - SEL_W'(1);
  endfunction

  function automatic logic [5:0] pick_color(input logic [6*NUM_FLAGS-1:0] flags,
                                            input logic [SEL_W-1:0] sel);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (sel == SEL_W'(i)) begin
        c = flags[6*i +: 6];
      end
    end
    return c;
  endfunction

  // Button synchroniser, debounce counters and 1-clk press pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      deb_r   <= 3'b000;
      press_r <= 3'b000;
      for (int b = 0; b < 3; b++) begin
        deb_cnt_r[b] <= DEB_W'(0);
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int b = 0; b < 3; b++) begin
        if (sync2_r[b] != deb_r[b]) begin
          if (deb_cnt_r[b] == DEB_W'(DEB_CYCLES - 1)) begin
            deb_r[b]     <= sync2_r[b];
            deb_cnt_r[b] <= DEB_W'(0);
            // only a rising debounced level counts as a press
            press_r[b]   <= sync2_r[b];
          end else begin
            deb_cnt_r[b] <= deb_cnt_r[b] + DEB_W'(1);
            press_r[b]   <= 1'b0;
          end
        end else begin
          deb_cnt_r[b] <= DEB_W'(0);
          press_r[b]   <= 1'b0;
        end
      end
    end
  end

  // Show/wipe sequencer and pause toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SHOW;
      cur_sel_r   <= SEL_W'(0);
      nxt_sel_r   <= SEL_W'(1 % NUM_FLAGS);
      paused_r    <= 1'b0;
      dwell_cnt_r <= 16'd0;
      wipe_x_r    <= 11'd0;
    end else begin
      if (press_r[2]) begin
        paused_r <= ~paused_r;
      end else begin
        paused_r <= paused_r;
      end
      case (state_r)
        SHOW: begin
          // a press beats a coincident auto-advance tick and supplies the target
          if (press_r[0] || press_r[1]) begin
            nxt_sel_r   <= press_r[0] ? sel_inc(cur_sel_r) : sel_dec(cur_sel_r);
            dwell_cnt_r <= 16'd0;
            wipe_x_r    <= 11'd0;
            state_r     <= WIPE;
          end else if (frame_tick && !paused_r) begin
            if (dwell_cnt_r == 16'(DWELL_FRAMES - 1)) begin
              nxt_sel_r   <= sel_inc(cur_sel_r);
              dwell_cnt_r <= 16'd0;
              wipe_x_r    <= 11'd0;
              state_r     <= WIPE;
            end else begin
              dwell_cnt_r <= dwell_cnt_r + 16'd1;
            end
          end else begin
            dwell_cnt_r <= dwell_cnt_r;
          end
        end
        WIPE: begin
          if (frame_tick) begin
            if (({1'b0, wipe_x_r} + 12'(WIPE_STEP)) >= 12'(H_ACTIVE)) begin
              cur_sel_r   <= nxt_sel_r;
              wipe_x_r    <= 11'd0;
              dwell_cnt_r <= 16'd0;
              state_r     <= SHOW;
            end else begin
              wipe_x_r <= wipe_x_r + 11'(WIPE_STEP);
            end
          end else begin
            wipe_x_r <= wipe_x_r;
          end
        end
        default: begin
          state_r  <= SHOW;
          wipe_x_r <= 11'd0;
        end
      endcase
    end
  end

  // Output colour: left of the wipe edge shows the incoming flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_r <= 6'd0;
    end else if ((state_r == WIPE) && ({1'b0, pix_x} < wipe_x_r)) begin
      color_r <= pick_color(flag_colors, nxt_sel_r);
    end else begin
      color_r <= pick_color(flag_colors, cur_sel_r);
    end
  end

  assign color   = color_r;
  assign cur_sel = cur_sel_r;
  assign nxt_sel = nxt_sel_r;
  assign paused  = paused_r;
  assign wiping  = (state_r == WIPE);

endmodule

// File: tb/tb_flag_show_sequencer.sv
// Scoreboard bench for flag_show_sequencer: directed steps push expected
// output snapshots, a negedge monitor pops and compares them.
module tb_flag_show_sequencer;

  localparam int NF = 5;
  localparam int SW = 3;

  logic          clk;
  logic          rst_n;
  logic          frame_tick;
  logic [9:0]    pix_x;
  logic [6*NF-1:0] flag_colors;
  logic          btn_next;
  logic          btn_prev;
  logic          btn_pause;
  logic [5:0]    color;
  logic [SW-1:0] cur_sel;
  logic [SW-1:0] nxt_sel;
  logic          paused;
  logic          wiping;

  typedef struct {
    string      name;
    logic [5:0] color;
    logic [2:0] cur;
    logic [2:0] nxt;
    logic       p;
    logic       w;
  } exp_t;

  exp_t q[$];
  logic chk_req;
  int   total;
  int   bad;

  flag_show_sequencer #(
    .NUM_FLAGS(NF), .SEL_W(SW), .DWELL_FRAMES(3), .WIPE_STEP(160),
    .H_ACTIVE(640), .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pix_x(pix_x),
    .flag_colors(flag_colors), .btn_next(btn_next), .btn_prev(btn_prev),
    .btn_pause(btn_pause), .color(color), .cur_sel(cur_sel), .nxt_sel(nxt_sel),
    .paused(paused), .wiping(wiping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NF; i++) flag_colors[6*i +: 6] = 6'(i + 1);
  end

  task automatic cmp(input string name, input string field, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    if (chk_req) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp(e.name, "color",   int'(color),   int'(e.color));
        cmp(e.name, "cur_sel", int'(cur_sel), int'(e.cur));
        cmp(e.name, "nxt_sel", int'(nxt_sel), int'(e.nxt));
        cmp(e.name, "paused",  int'(paused),  int'(e.p));
        cmp(e.name, "wiping",  int'(wiping),  int'(e.w));
      end
    end
  end

  task automatic expect_out(input string name, input logic [5:0] c, input logic [2:0] cur,
                            input logic [2:0] nxt, input logic p, input logic w);
    exp_t e;
    @(posedge clk); #1;
    e.name = name; e.color = c; e.cur = cur; e.nxt = nxt; e.p = p; e.w = w;
    q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
  endtask

  // mask = {pause, prev, next}
  task automatic press(input logic [2:0] mask, input int n);
    @(posedge clk); #1 {btn_pause, btn_prev, btn_next} = mask;
    repeat (n) @(posedge clk);
    #1 {btn_pause, btn_prev, btn_next} = 3'b000;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; chk_req = 1'b0;
    rst_n = 1'b0; frame_tick = 1'b0; pix_x = 10'd700;
    btn_next = 1'b0; btn_prev = 1'b0; btn_pause = 1'b0;
    expect_out("in_reset", 6'd0, 3'd0, 3'd1, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_out("reset", 6'd1, 3'd0, 3'd1, 1'b0, 1'b0);

    // auto-advance after three ticks, wipe lasts four ticks
    ticks(2);
    expect_out("auto_dwell", 6'd1, 3'd0, 3'd1, 1'b0, 1'b0);
    ticks(1);
    expect_out("auto_wipe", 6'd1, 3'd0, 3'd1, 1'b0, 1'b1);
    ticks(2);
    pix_x = 10'd319;
    expect_out("wipe_left", 6'd2, 3'd0, 3'd1, 1'b0, 1'b1);
    pix_x = 10'd320;
    expect_out("wipe_edge", 6'd1, 3'd0, 3'd1, 1'b0, 1'b1);
    pix_x = 10'd700;
    ticks(2);
    expect_out("auto_done", 6'd2, 3'd1, 3'd1, 1'b0, 1'b0);

    // prev back to 0, then prev wraps to the last flag
    press(3'b010, 6);
    expect_out("prev_to0", 6'd2, 3'd1, 3'd0, 1'b0, 1'b1);
    ticks(4);
    expect_out("at_flag0", 6'd1, 3'd0, 3'd0, 1'b0, 1'b0);
    press(3'b010, 6);
    expect_out("prev_wrap", 6'd1, 3'd0, 3'd4, 1'b0, 1'b1);
    ticks(4);
    expect_out("at_flag4", 6'd5, 3'd4, 3'd4, 1'b0, 1'b0);
    press(3'b001, 2);
    expect_out("glitch", 6'd5, 3'd4, 3'd4, 1'b0, 1'b0);

    // pause holds the flag, resume continues the dwell count
    press(3'b100, 6);
    expect_out("pause_on", 6'd5, 3'd4, 3'd4, 1'b1, 1'b0);
    ticks(10);
    expect_out("pause_hold", 6'd5, 3'd4, 3'd4, 1'b1, 1'b0);
    press(3'b100, 6);
    expect_out("pause_off", 6'd5, 3'd4, 3'd4, 1'b0, 1'b0);
    ticks(2);
    expect_out("resume_dwell", 6'd5, 3'd4, 3'd4, 1'b0, 1'b0);
    ticks(1);
    expect_out("resume_wipe", 6'd5, 3'd4, 3'd0, 1'b0, 1'b1);
    ticks(4);
    expect_out("at_flag0b", 6'd1, 3'd0, 3'd0, 1'b0, 1'b0);

    // collisions: next wins over prev, presses during wipe are dropped
    press(3'b011, 6);
    expect_out("next_prev", 6'd1, 3'd0, 3'd1, 1'b0, 1'b1);
    press(3'b001, 6);
    expect_out("wipe_drop", 6'd1, 3'd0, 3'd1, 1'b0, 1'b1);
    ticks(3);
    expect_out("wipe_tick3", 6'd1, 3'd0, 3'd1, 1'b0, 1'b1);
    ticks(1);
    expect_out("wipe_tick4", 6'd2, 3'd1, 3'd1, 1'b0, 1'b0);

    // pause with next in the same clock, then reset mid-wipe
    press(3'b101, 6);
    expect_out("next_pause", 6'd2, 3'd1, 3'd2, 1'b1, 1'b1);
    ticks(1);
    pix_x = 10'd100;
    expect_out("mid_160", 6'd3, 3'd1, 3'd2, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    expect_out("rst_mid", 6'd0, 3'd0, 3'd1, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_out("rst_release", 6'd1, 3'd0, 3'd1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
